// File: rtl/warp_xdiv_iter_pkg.sv
// Shared types for the iterative integer divider.
// FSM encoding and the legal-configuration check live here.
package warp_xdiv_iter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } xdiv_state_e;

  function automatic bit unroll_ok(
    input int unroll,
    input int xlen
  );
    return (unroll == 1 || unroll == 2 || unroll == 4)
        && (xlen >= 8) && (xlen % 2 == 0)
        && ((xlen / 2) % unroll == 0);
  endfunction

endpackage

// File: rtl/warp_xdiv_step.sv
// One restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor, keep or restore, emit a quotient bit.
module warp_xdiv_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] dvd_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] dvd_o
);

  logic [XLEN:0] sh;
  logic [XLEN:0] diff;
  logic          qbit;

  always_comb begin
    sh    = {rem_i, dvd_i[XLEN-1]};
    diff  = sh - {1'b0, div_i};
    qbit  = ~diff[XLEN];
    rem_o = qbit ? diff[XLEN-1:0] : sh[XLEN-1:0];
    dvd_o = {dvd_i[XLEN-2:0], qbit};
  end

endmodule

// File: rtl/warp_xdiv_iter.sv
// Iterative signed/unsigned integer divider, UNROLL bits per cycle.
// The dividend register doubles as the quotient shift register.
module warp_xdiv_iter
  import warp_xdiv_iter_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int UNROLL = 1,
  parameter int TAG_W  = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_input_valid,
  output logic             o_input_ready,
  input  logic [XLEN-1:0]  i_op1,
  input  logic [XLEN-1:0]  i_op2,
  input  logic             i_unsigned,
  input  logic             i_word,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_flush,
  output logic             o_valid,
  output logic [XLEN-1:0]  o_quotient,
  output logic [XLEN-1:0]  o_remainder,
  output logic [TAG_W-1:0] o_tag
);

  localparam int H  = XLEN / 2;
  localparam int CW = $clog2(XLEN / UNROLL + 1);
  localparam logic [CW-1:0] N_FULL = CW'(XLEN / UNROLL - 1);
  localparam logic [CW-1:0] N_WORD = CW'(H / UNROLL - 1);
  localparam logic [XLEN-1:0] MIN_F =
    {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W =
    {{(H+1){1'b1}}, {(H-1){1'b0}}};

  if (!unroll_ok(UNROLL, XLEN)) begin : g_bad_cfg
    $error("warp_xdiv_iter: illegal XLEN/UNROLL");
  end

  function automatic logic [XLEN-1:0] sext_h(
    input logic [H-1:0] x
  );
    return {{H{x[H-1]}}, x};
  endfunction

  xdiv_state_e      state_q;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  dvd_q;
  logic [XLEN-1:0]  div_q;
  logic [CW-1:0]    cnt_q;
  logic             negq_q;
  logic             negr_q;
  logic             word_q;
  logic [TAG_W-1:0] tag_q;
  logic             valid_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  rmd_q;
  logic [TAG_W-1:0] otag_q;

  logic [XLEN-1:0] ext1, ext2;
  logic [XLEN-1:0] mag1, mag2;
  logic [XLEN-1:0] dvd_d;
  logic            neg1, neg2;
  logic            dz, ovf;
  logic [XLEN-1:0] quo_d, rmd_d;

  // Operands are normalised to XLEN-wide values at the active width
  always_comb begin
    ext1 = i_op1;
    ext2 = i_op2;
    if (i_word) begin
      ext1 = i_unsigned ? {{H{1'b0}}, i_op1[H-1:0]}
                        : sext_h(i_op1[H-1:0]);
      ext2 = i_unsigned ? {{H{1'b0}}, i_op2[H-1:0]}
                        : sext_h(i_op2[H-1:0]);
    end
    neg1  = ~i_unsigned & ext1[XLEN-1];
    neg2  = ~i_unsigned & ext2[XLEN-1];
    mag1  = neg1 ? -ext1 : ext1;
    mag2  = neg2 ? -ext2 : ext2;
    dvd_d = i_word ? {mag1[H-1:0], {H{1'b0}}} : mag1;
    dz    = i_word ? (i_op2[H-1:0] == '0)
                   : (i_op2 == '0);
    ovf   = ~i_unsigned & (ext2 == '1)
          & (ext1 == (i_word ? MIN_W : MIN_F));
  end

  always_comb begin
    quo_d = negq_q ? -dvd_q : dvd_q;
    rmd_d = negr_q ? -rem_q : rem_q;
    if (word_q) begin
      quo_d = sext_h(quo_d[H-1:0]);
      rmd_d = sext_h(rmd_d[H-1:0]);
    end
  end

  logic [XLEN-1:0] rem_c [0:UNROLL];
  logic [XLEN-1:0] dvd_c [0:UNROLL];

  assign rem_c[0] = rem_q;
  assign dvd_c[0] = dvd_q;

  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    warp_xdiv_step #(
      .XLEN (XLEN)
    ) u_step (
      .rem_i (rem_c[g]),
      .dvd_i (dvd_c[g]),
      .div_i (div_q),
      .rem_o (rem_c[g+1]),
      .dvd_o (dvd_c[g+1])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      dvd_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      word_q  <= 1'b0;
      tag_q   <= '0;
      valid_q <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      otag_q  <= '0;
    end else if (i_flush) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (i_input_valid) begin
            tag_q  <= i_tag;
            word_q <= i_word;
            div_q  <= mag2;
            cnt_q  <= i_word ? N_WORD : N_FULL;
            if (dz) begin
              dvd_q   <= '1;
              rem_q   <= i_word ? sext_h(i_op1[H-1:0])
                                : i_op1;
              negq_q  <= 1'b0;
              negr_q  <= 1'b0;
              state_q <= ST_DONE;
            end else if (ovf) begin
              dvd_q   <= ext1;
              rem_q   <= '0;
              negq_q  <= 1'b0;
              negr_q  <= 1'b0;
              state_q <= ST_DONE;
            end else begin
              dvd_q   <= dvd_d;
              rem_q   <= '0;
              negq_q  <= neg1 ^ neg2;
              negr_q  <= neg1;
              state_q <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          rem_q <= rem_c[UNROLL];
          dvd_q <= dvd_c[UNROLL];
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          valid_q <= 1'b1;
          quo_q   <= quo_d;
          rmd_q   <= rmd_d;
          otag_q  <= tag_q;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_input_ready = (state_q == ST_IDLE);
  assign o_valid       = valid_q;
  assign o_quotient    = quo_q;
  assign o_remainder   = rmd_q;
  assign o_tag         = otag_q;

endmodule

// File: tb/tb_warp_xdiv_iter.sv
// Randomised self-checking bench: UNROLL=1 and UNROLL=4 divider
// instances share stimulus and are compared to a plain-arithmetic model.
module tb_warp_xdiv_iter;

  localparam int XLEN  = 64;
  localparam int TAG_W = 5;

  logic             clk   = 1'b0;
  logic             rst   = 1'b1;
  logic             vin   = 1'b0;
  logic             uns   = 1'b0;
  logic             word  = 1'b0;
  logic             flush = 1'b0;
  logic [XLEN-1:0]  op1   = '0;
  logic [XLEN-1:0]  op2   = '0;
  logic [TAG_W-1:0] tag   = '0;

  logic             rdy1, rdy4, v1, v4;
  logic [XLEN-1:0]  q1, r1, q4, r4;
  logic [TAG_W-1:0] t1, t4;

  int n_chk = 0;
  int n_err = 0;
  int nv1   = 0;
  int nv4   = 0;

  always #5 clk = ~clk;

  warp_xdiv_iter #(
    .XLEN (XLEN), .UNROLL (1), .TAG_W (TAG_W)
  ) u_dut1 (
    .i_clk (clk), .i_rst (rst),
    .i_input_valid (vin), .o_input_ready (rdy1),
    .i_op1 (op1), .i_op2 (op2),
    .i_unsigned (uns), .i_word (word),
    .i_tag (tag), .i_flush (flush),
    .o_valid (v1), .o_quotient (q1),
    .o_remainder (r1), .o_tag (t1)
  );

  warp_xdiv_iter #(
    .XLEN (XLEN), .UNROLL (4), .TAG_W (TAG_W)
  ) u_dut4 (
    .i_clk (clk), .i_rst (rst),
    .i_input_valid (vin), .o_input_ready (rdy4),
    .i_op1 (op1), .i_op2 (op2),
    .i_unsigned (uns), .i_word (word),
    .i_tag (tag), .i_flush (flush),
    .o_valid (v4), .o_quotient (q4),
    .o_remainder (r4), .o_tag (t4)
  );

  always @(negedge clk) begin
    if (v1) nv1++;
    if (v4) nv4++;
  end

  task automatic chk(
    input string       nm,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic void ref_div(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  bit          u,
    input  bit          w,
    output logic [63:0] q,
    output logic [63:0] r,
    output bit          sp
  );
    logic [31:0] a32, b32, q32, r32;
    int          sa, sb;
    longint      la, lb;
    sp = 1'b0;
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 0) begin
        q32 = '1; r32 = a32; sp = 1'b1;
      end else if (!u && a32 == 32'h8000_0000
                   && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = '0; sp = 1'b1;
      end else if (u) begin
        q32 = a32 / b32; r32 = a32 % b32;
      end else begin
        sa = a32; sb = b32;
        q32 = 32'(sa / sb); r32 = 32'(sa % sb);
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 0) begin
        q = '1; r = a; sp = 1'b1;
      end else if (!u && a == 64'h8000_0000_0000_0000
                   && b == '1) begin
        q = a; r = '0; sp = 1'b1;
      end else if (u) begin
        q = a / b; r = a % b;
      end else begin
        la = a; lb = b;
        q = 64'(la / lb); r = 64'(la % lb);
      end
    end
  endfunction

  task automatic do_op(
    input logic [63:0] a,
    input logic [63:0] b,
    input bit          u,
    input bit          w,
    input logic [4:0]  tg
  );
    logic [63:0] eq, er, cq1, cr1, cq4, cr4;
    logic [4:0]  ct1, ct4;
    bit          sp;
    bit          g1 = 1'b0;
    bit          g4 = 1'b0;
    int          l1e, l4e;
    int          lat1 = -1;
    int          lat4 = -1;
    cq1 = '0; cr1 = '0; cq4 = '0; cr4 = '0;
    ct1 = '0; ct4 = '0;
    ref_div(a, b, u, w, eq, er, sp);
    l1e = sp ? 1 : (w ? 32 : 64) + 1;
    l4e = sp ? 1 : (w ? 32 : 64) / 4 + 1;
    @(negedge clk);
    chk("ready", {63'b0, rdy1 & rdy4}, 64'd1);
    op1 = a; op2 = b; uns = u; word = w; tag = tg;
    vin = 1'b1;
    @(posedge clk);
    #1;
    vin  = 1'b0;
    op1  = {$urandom, $urandom};
    op2  = {$urandom, $urandom};
    uns  = ~u;
    word = ~w;
    tag  = ~tg;
    for (int c = 0; c <= 80 && !(g1 && g4); c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      if (v1 && !g1) begin
        g1 = 1'b1; lat1 = c;
        cq1 = q1; cr1 = r1; ct1 = t1;
      end
      if (v4 && !g4) begin
        g4 = 1'b1; lat4 = c;
        cq4 = q4; cr4 = r4; ct4 = t4;
      end
    end
    chk("done1", {63'b0, g1}, 64'd1);
    chk("done4", {63'b0, g4}, 64'd1);
    chk("lat1", 64'(lat1), 64'(l1e));
    chk("lat4", 64'(lat4), 64'(l4e));
    chk("quo1", cq1, eq);
    chk("rem1", cr1, er);
    chk("tag1", 64'(ct1), 64'(tg));
    chk("quo4", cq4, eq);
    chk("rem4", cr4, er);
    chk("tag4", 64'(ct4), 64'(tg));
    @(posedge clk);
    #1;
    chk("pulse1", {63'b0, v1}, 64'd0);
    chk("hold1", q1, eq);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int b1, b4;
    logic [63:0] a, b;
    bit u, w;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {63'b0, v1}, 64'd0);
    chk("rst_quo", q1, 64'd0);
    chk("rst_rem", r1, 64'd0);
    chk("rst_tag", 64'(t1), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_ready", {63'b0, rdy1}, 64'd1);

    do_op(64'd100, 64'd7, 1'b1, 1'b0, 5'd1);
    do_op(-64'sd7, 64'd2, 1'b0, 1'b0, 5'd2);
    do_op(64'd5, 64'd0, 1'b0, 1'b0, 5'd3);
    do_op(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
          1'b0, 1'b1, 5'd5);
    do_op(64'h0000_0000_FFFF_FFFF, 64'h10, 1'b1, 1'b1, 5'd6);
    do_op(64'h8000_0000_0000_0000, '1, 1'b0, 1'b0, 5'd7);
    do_op(64'hABCD_0000_0000_0000, 64'h1234_0000_0000_0000,
          1'b0, 1'b1, 5'd8);

    b1 = nv1; b4 = nv4;
    @(negedge clk);
    op1 = 64'd100; op2 = 64'd7; uns = 1'b0; word = 1'b0;
    tag = 5'd9; vin = 1'b1;
    @(posedge clk);
    #1;
    vin = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_ready", {63'b0, rdy1 & rdy4}, 64'd1);
    do_op(64'd9, 64'd3, 1'b0, 1'b0, 5'd4);
    chk("flush_cnt1", 64'(nv1 - b1), 64'd1);
    chk("flush_cnt4", 64'(nv4 - b4), 64'd1);

    b1 = nv1; b4 = nv4;
    @(negedge clk);
    op1 = 64'd100; op2 = 64'd7; tag = 5'd10;
    vin = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    vin = 1'b0; flush = 1'b0;
    chk("accflush_rdy", {63'b0, rdy1 & rdy4}, 64'd1);
    repeat (70) @(posedge clk);
    chk("accflush_cnt", 64'((nv1 - b1) + (nv4 - b4)), 64'd0);

    b1 = nv1;
    @(negedge clk);
    op1 = 64'd1000; op2 = 64'd3; tag = 5'd11; vin = 1'b1;
    @(posedge clk);
    #1;
    vin = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_ready", {63'b0, rdy1}, 64'd1);
    chk("midrst_quo", q1, 64'd0);
    chk("midrst_rem", r1, 64'd0);
    chk("midrst_tag", 64'(t1), 64'd0);
    repeat (70) @(posedge clk);
    chk("midrst_cnt", 64'(nv1 - b1), 64'd0);

    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      u = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: b = {$urandom, 32'h0};
        1: begin
          u = 1'b0;
          b = w ? {$urandom, 32'hFFFF_FFFF} : '1;
          a = w ? {$urandom, 32'h8000_0000}
                : 64'h8000_0000_0000_0000;
        end
        2: b = 64'($urandom_range(1, 20));
        3: b = -64'($urandom_range(1, 20));
        4: b = 64'($urandom);
        default: ;
      endcase
      do_op(a, b, u, w, 5'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
